// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq
//  Description : Iterative RV32M multiply/divide sequencer. Radix-2
//                shift-add multiply and restoring divide, one bit per cycle,
//                followed by a sign fix-up step and a held, handshaked result.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int              c_cnt_w    = $clog2(XLEN) + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(XLEN - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_calc  = 2'd1;
    localparam logic [1:0] c_st_fixup = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    localparam logic [2:0] c_f_mul    = 3'd0;
    localparam logic [2:0] c_f_mulh   = 3'd1;
    localparam logic [2:0] c_f_mulhsu = 3'd2;
    localparam logic [2:0] c_f_mulhu  = 3'd3;
    localparam logic [2:0] c_f_div    = 3'd4;
    localparam logic [2:0] c_f_divu   = 3'd5;
    localparam logic [2:0] c_f_rem    = 3'd6;

    localparam logic [XLEN-1:0] c_int_min = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [2:0]          r_func3;
    logic [c_cnt_w-1:0]  r_cnt;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide  : {partial remainder, dividend bits / quotient bits}.
    logic [2*XLEN-1:0]   r_acc;
    // Multiplicand magnitude (multiply) or divisor magnitude (divide).
    logic [XLEN-1:0]     r_opb;
    logic                r_neg_q;   // negate product or quotient
    logic                r_neg_r;   // negate remainder
    logic [XLEN-1:0]     r_result;

    logic                w_accept;
    logic                w_last;
    logic                w_sgn1;
    logic                w_sgn2;
    logic [XLEN-1:0]     w_mag1;
    logic [XLEN-1:0]     w_mag2;
    logic                w_div_zero;
    logic                w_ovf;
    logic                w_special;

    logic [XLEN:0]       w_mul_sum;
    logic [XLEN:0]       w_div_hi;
    logic                w_div_ge;
    logic [XLEN-1:0]     w_div_diff;

    logic [2*XLEN-1:0]   w_prod_fix;
    logic [XLEN-1:0]     w_quot_fix;
    logic [XLEN-1:0]     w_rem_fix;
    logic [XLEN-1:0]     w_res_sel;

    // Flush blocks a same-cycle accept so a redirected request never starts.
    assign w_accept = in_valid & (r_state == c_st_idle) & ~flush;
    assign w_last   = (r_cnt == c_cnt_last);

    // Effective operand signs: only the signed operand positions count.
    assign w_sgn1 = rs1[XLEN-1] & ((func3 == c_f_mulh) | (func3 == c_f_mulhsu) |
                                   (func3 == c_f_div)  | (func3 == c_f_rem));
    assign w_sgn2 = rs2[XLEN-1] & ((func3 == c_f_mulh) | (func3 == c_f_div) |
                                   (func3 == c_f_rem));
    assign w_mag1 = w_sgn1 ? -rs1 : rs1;
    assign w_mag2 = w_sgn2 ? -rs2 : rs2;

    // Results fully known at accept; these skip the iteration entirely.
    assign w_div_zero = func3[2] & (rs2 == '0);
    assign w_ovf      = ((func3 == c_f_div) | (func3 == c_f_rem)) &
                        (rs1 == c_int_min) & (rs2 == '1);
    assign w_special  = w_div_zero | w_ovf;

    // One multiply step: conditional add into the upper half, then shift.
    assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                       (r_acc[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});

    // One restoring divide step on the left-shifted {rem, quot} pair. The
    // shifted remainder needs one extra bit; the difference fits in XLEN
    // whenever it is kept.
    assign w_div_hi   = r_acc[2*XLEN-1:XLEN-1];
    assign w_div_ge   = (w_div_hi >= {1'b0, r_opb});
    assign w_div_diff = w_div_hi[XLEN-1:0] - r_opb;

    // Sign fix-up and result selection.
    assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
    assign w_quot_fix = r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem_fix  = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

    // Pick the architectural result for the latched operation.
    always_comb begin
        w_res_sel = w_prod_fix[2*XLEN-1:XLEN];
        case (r_func3)
            c_f_mul:                       w_res_sel = w_prod_fix[XLEN-1:0];
            c_f_mulh, c_f_mulhsu, c_f_mulhu: w_res_sel = w_prod_fix[2*XLEN-1:XLEN];
            c_f_div, c_f_divu:             w_res_sel = w_quot_fix;
            default:                       w_res_sel = w_rem_fix;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush overrides everything, including the handshake.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (w_accept) w_state_nxt = w_special ? c_st_fixup : c_st_calc;
            c_st_calc:  if (w_last)   w_state_nxt = c_st_fixup;
            c_st_fixup: w_state_nxt = c_st_done;
            c_st_done:  if (out_ready) w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
        if (flush) begin
            w_state_nxt = c_st_idle;
        end
    end

    // Operand capture, iteration datapath and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_func3  <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_func3 <= func3;
            r_cnt   <= '0;
            if (w_div_zero) begin
                r_acc   <= {rs1, {XLEN{1'b1}}};
                r_opb   <= '0;
                r_neg_q <= 1'b0;
                r_neg_r <= 1'b0;
            end else if (w_ovf) begin
                r_acc   <= {{XLEN{1'b0}}, c_int_min};
                r_opb   <= '0;
                r_neg_q <= 1'b0;
                r_neg_r <= 1'b0;
            end else if (func3[2]) begin
                r_acc   <= {{XLEN{1'b0}}, w_mag1};
                r_opb   <= w_mag2;
                r_neg_q <= w_sgn1 ^ w_sgn2;
                r_neg_r <= w_sgn1;
            end else begin
                r_acc   <= {{XLEN{1'b0}}, w_mag2};
                r_opb   <= w_mag1;
                r_neg_q <= w_sgn1 ^ w_sgn2;
                r_neg_r <= 1'b0;
            end
        end else if (r_state == c_st_calc) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
            if (r_func3[2]) begin
                r_acc <= {(w_div_ge ? w_div_diff : w_div_hi[XLEN-1:0]),
                          r_acc[XLEN-2:0], w_div_ge};
            end else begin
                r_acc <= {w_mul_sum, r_acc[XLEN-1:1]};
            end
        end else if ((r_state == c_st_fixup) && !flush) begin
            r_result <= w_res_sel;
        end
    end

    assign in_ready  = (r_state == c_st_idle);
    assign busy      = (r_state != c_st_idle);
    assign out_valid = (r_state == c_st_done);
    assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_seq
//  Description : Scoreboard bench for muldiv_seq: directed RV32M cases,
//                special cases, backpressure, reset, flush and random ops.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  func3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    muldiv_seq #(.XLEN(32)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .func3     (func3),
        .rs1       (rs1),
        .rs2       (rs2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference RV32M semantics.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        ea;
        logic [63:0]        eb;
        logic [63:0]        p;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        r;
        ea = {32'h0, a};
        eb = {32'h0, b};
        if (f == 3'd1 || f == 3'd2) ea = {{32{a[31]}}, a};
        if (f == 3'd1)              eb = {{32{b[31]}}, b};
        p  = ea * eb;
        sa = a;
        sb = b;
        r  = 32'h0;
        case (f)
            3'd0: r = p[31:0];
            3'd1, 3'd2, 3'd3: r = p[63:32];
            3'd4: if (b == 0) r = 32'hFFFF_FFFF;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                  else r = sa / sb;
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: if (b == 0) r = a;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
                  else r = sa % sb;
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return 2;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    // Present one request; returns at the falling edge of cycle 1.
    task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        check_val("in_ready_before_accept", {31'h0, in_ready}, 32'h1);
        in_valid = 1'b1;
        func3    = f;
        rs1      = a;
        rs2      = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        func3    = 3'($urandom);
        rs1      = $urandom;
        rs2      = $urandom;
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int bp);
        int          cyc;
        logic [31:0] want;
        exp_q.push_back(exp);
        start_op(f, a, b);
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check_val({tag, "_latency"}, 32'(cyc), 32'(model_lat(f, a, b)));
        want = exp_q.pop_front();
        check_val(tag, result, want);
        check_val({tag, "_busy"}, {31'h0, busy}, 32'h1);
        check_val({tag, "_in_ready_low"}, {31'h0, in_ready}, 32'h0);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check_val({tag, "_hold_valid"}, {31'h0, out_valid}, 32'h1);
            check_val({tag, "_hold_result"}, result, want);
            check_val({tag, "_hold_in_ready"}, {31'h0, in_ready}, 32'h0);
            check_val({tag, "_hold_busy"}, {31'h0, busy}, 32'h1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_val({tag, "_post_valid"}, {31'h0, out_valid}, 32'h0);
        check_val({tag, "_post_in_ready"}, {31'h0, in_ready}, 32'h1);
        check_val({tag, "_post_result"}, result, want);
    endtask

    initial begin
        int          seen;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        rst       = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        func3     = 3'd0;
        rs1       = 32'h0;
        rs2       = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_val("reset_in_ready", {31'h0, in_ready}, 32'h1);
        check_val("reset_out_valid", {31'h0, out_valid}, 32'h0);
        check_val("reset_busy", {31'h0, busy}, 32'h0);
        check_val("reset_result", result, 32'h0);

        run_op("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        run_op("mulhsu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);

        // Reset in the middle of an operation.
        start_op(3'd0, 32'd123, 32'd456);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_val("midreset_in_ready", {31'h0, in_ready}, 32'h1);
        check_val("midreset_out_valid", {31'h0, out_valid}, 32'h0);
        check_val("midreset_result", result, 32'h0);
        run_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);

        run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
        run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
        run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 0);
        run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2, 0);
        run_op("divu_by0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        run_op("remu_by0", 3'd7, 32'd5, 32'd0, 32'd5, 0);
        run_op("div_by0_neg", 3'd4, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFF, 0);
        run_op("rem_by0_neg", 3'd6, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 0);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0);

        // Backpressure: consumer stalls for five cycles.
        run_op("bp_mul", 3'd0, 32'd1000, 32'd1000, 32'd1000000, 5);

        // Flush in the middle of a divide.
        start_op(3'd4, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check_val("flush_in_ready", {31'h0, in_ready}, 32'h1);
        check_val("flush_out_valid", {31'h0, out_valid}, 32'h0);
        check_val("flush_busy", {31'h0, busy}, 32'h0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check_val("flush_no_result", 32'(seen), 32'h0);
        run_op("mul_3_4", 3'd0, 32'd3, 32'd4, 32'd12, 0);

        // Flush together with a request in IDLE: not accepted.
        @(negedge clk);
        in_valid = 1'b1;
        flush    = 1'b1;
        func3    = 3'd0;
        rs1      = 32'd9;
        rs2      = 32'd9;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        check_val("idle_flush_busy", {31'h0, busy}, 32'h0);
        check_val("idle_flush_in_ready", {31'h0, in_ready}, 32'h1);

        // Random operations against the reference model.
        for (int k = 0; k < 16; k++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if (k % 5 == 1) b = $urandom_range(1, 20);
            if (k % 7 == 3) b = 32'h0;
            run_op("random", f, a, b, model(f, a, b), k % 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
